bcci_axis_out_packer: RTL

Output-side successor to the fixed-width upsampler stream port. It takes one upsampled pixel per handshake from the interpolation core and packs PIXELS_PER_BEAT pixels of CHANNELS x CHANNEL_WIDTH bits into each AXI4-Stream output beat. It generates tuser on the first beat of the frame and tlast on the last beat of each destination row. When the final beat of a frame is accepted, it raises interrupt_updone for one cycle. It sits between the upsampling datapath and the m_axis port of the IP top.

---
 rtl/bcci_out_pkg.sv | 18 +
 rtl/bcci_axis_out_reg.sv | 54 +++++
 rtl/bcci_axis_out_packer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcci_out_pkg.sv
// Shared types and helpers for the AXI4-Stream output packer.
package bcci_out_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  // Byte size of one pixel in the default 3 x 8-bit configuration.
  localparam int PIXEL_BYTES = 3;
  localparam int MAX_KEEP    = 256;

  function automatic logic [MAX_KEEP-1:0] keep_mask(input int n_lanes,
                                                    input int pix_bytes = PIXEL_BYTES);
    logic [MAX_KEEP-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_KEEP; i++) m[i] = (i < n_lanes * pix_bytes);
    return m;
  endfunction

endpackage

// File: rtl/bcci_axis_out_reg.sv
// Single-entry AXI4-Stream output holding register; free_o says a new beat may load now.
module bcci_axis_out_reg #(
  parameter int DW = 96,
  parameter int KW = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [KW-1:0] keep_i,
  input  logic          last_i,
  input  logic          user_i,
  input  logic          tready_i,
  output logic          tvalid_o,
  output logic [DW-1:0] tdata_o,
  output logic [KW-1:0] tkeep_o,
  output logic          tlast_o,
  output logic          user_o,
  output logic          free_o
);

  logic          vld_q;
  logic [DW-1:0] data_q;
  logic [KW-1:0] keep_q;
  logic          last_q, user_q;

  assign free_o = !vld_q || tready_i;

  // Load may coincide with the drain of the previous beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      user_q <= 1'b0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      data_q <= data_i;
      keep_q <= keep_i;
      last_q <= last_i;
      user_q <= user_i;
    end else if (tready_i) begin
      vld_q  <= 1'b0;
    end
  end

  assign tvalid_o = vld_q;
  assign tdata_o  = data_q;
  assign tkeep_o  = keep_q;
  assign tlast_o  = last_q;
  assign user_o   = user_q;

endmodule

// File: rtl/bcci_axis_out_packer.sv
// Packs upsampled pixels into AXI4-Stream beats with row tlast, frame tuser and a done pulse.
module bcci_axis_out_packer
  import bcci_out_pkg::*;
#(
  parameter int CHANNEL_WIDTH      = 8,
  parameter int CHANNELS           = 3,
  parameter int PIXELS_PER_BEAT    = 4,
  parameter int AXISOUT_DATA_WIDTH = PIXELS_PER_BEAT * CHANNELS * CHANNEL_WIDTH,
  parameter int DST_IMG_WIDTH      = 3840,
  parameter int DST_IMG_HEIGHT     = 2160
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_start,
  output logic                                busy,
  input  logic                                s_pix_valid,
  output logic                                s_pix_ready,
  input  logic [CHANNELS*CHANNEL_WIDTH-1:0]   s_pix_data,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [AXISOUT_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [AXISOUT_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [AXISOUT_DATA_WIDTH/8-1:0]     m_axis_tstrb,
  output logic                                m_axis_tlast,
  output logic                                m_axis_user,
  output logic                                interrupt_updone
);

  localparam int PPB = PIXELS_PER_BEAT;
  localparam int PW  = CHANNELS * CHANNEL_WIDTH;
  localparam int PB  = PW / 8;
  localparam int KW  = AXISOUT_DATA_WIDTH / 8;
  localparam int CW  = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
  localparam int RW  = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
  localparam int LW  = (PPB > 1) ? $clog2(PPB) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(DST_IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(DST_IMG_HEIGHT - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(PPB - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [PPB-1:0][PW-1:0] acc_q, acc_d, beat;
  logic [KW-1:0]        beat_keep;
  logic                 beat_last, beat_user;
  logic                 completes, out_free, pix_ack, load;

  always_comb begin
    completes   = (lane_q == LANE_LAST) || (col_q == COL_LAST);
    s_pix_ready = (state_q == RUN) && (!completes || out_free);
    pix_ack     = s_pix_valid && s_pix_ready;
    load        = pix_ack && completes;
    // Completing pixel is merged straight into the beat; lanes above it read as zero.
    beat = '0;
    for (int k = 0; k < PPB; k++) begin
      if (k < int'(lane_q))       beat[k] = acc_q[k];
      else if (k == int'(lane_q)) beat[k] = s_pix_data;
    end
    beat_keep = KW'(keep_mask(int'(lane_q) + 1, PB));
    beat_last = (col_q == COL_LAST);
    beat_user = (row_q == '0) && (int'(col_q) == int'(lane_q));
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    lane_d  = lane_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: if (cfg_start) begin
        state_d = RUN;
        col_d   = '0;
        row_d   = '0;
        lane_d  = '0;
      end
      RUN: if (pix_ack) begin
        acc_d[lane_q] = s_pix_data;
        if (col_q == COL_LAST) begin
          col_d  = '0;
          lane_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = FLUSH;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d  = col_q + CW'(1);
          lane_d = completes ? '0 : lane_q + LW'(1);
        end
      end
      FLUSH: if (m_axis_tvalid && m_axis_tready) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      lane_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      lane_q  <= lane_d;
      acc_q   <= acc_d;
    end
  end

  assign busy             = (state_q == RUN) || (state_q == FLUSH);
  assign interrupt_updone = (state_q == DONE);
  assign m_axis_tstrb     = m_axis_tkeep;

  bcci_axis_out_reg #(.DW(AXISOUT_DATA_WIDTH), .KW(KW)) u_out (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (load),
    .data_i   (beat),
    .keep_i   (beat_keep),
    .last_i   (beat_last),
    .user_i   (beat_user),
    .tready_i (m_axis_tready),
    .tvalid_o (m_axis_tvalid),
    .tdata_o  (m_axis_tdata),
    .tkeep_o  (m_axis_tkeep),
    .tlast_o  (m_axis_tlast),
    .user_o   (m_axis_user),
    .free_o   (out_free)
  );

endmodule
